bk_sum_accumulator: RTL and testbench

//   Downstream consumer of the 16-bit Brent-Kung adder's 17-bit sum S[16:0].

---
 rtl/bk_sum_accumulator.sv | 143 ++++++++++++++
 tb/tb_bk_sum_accumulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bk_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : bk_sum_accumulator
// Purpose  : Frame accumulator for the 17-bit Brent-Kung adder sum. Accepts
//            one unsigned sum per cycle over valid/ready, accumulates cfg_len
//            sums into a saturating ACC_W-bit register, then presents the
//            frame total, beat count and sticky overflow flag on a
//            valid/ready result port.
// Ports    : clk      - clock, all state on rising edge
//            rst_n    - synchronous reset, active-low
//            cfg_len  - sums per frame, sampled on first beat (0 => 2^LEN_W)
//            s_valid  - input sum valid
//            s_ready  - block can accept a sum this cycle
//            s_sum    - unsigned sum from adder
//            m_valid  - frame result valid
//            m_ready  - downstream accepts result
//            m_acc    - saturated frame total
//            m_count  - beats in frame (wraps to 0 for 2^LEN_W-beat frames)
//            m_ovf    - accumulation saturated at least once in this frame
//            busy     - block is not idle
// Revision : 1.0 - initial release
// ============================================================================
module bk_sum_accumulator #(
    parameter int SUM_W = 17,
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SUM_W-1:0] s_sum,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_acc,
    output logic [LEN_W-1:0] m_count,
    output logic             m_ovf,
    output logic             busy
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_accum = 2'd1;
    localparam logic [1:0] c_hold  = 2'd2;

    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] c_acc_max = {ACC_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] w_count_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;

    logic             w_beat;
    logic [ACC_W:0]   w_sum_zext;
    logic [ACC_W:0]   w_acc_sum;
    logic [LEN_W-1:0] w_count_inc;

    // Accept sums whenever no result is pending; depends only on state so
    // there is no combinational path from s_valid to m_valid.
    assign s_ready = (r_state != c_hold);
    assign w_beat  = s_valid & s_ready;

    // One guard bit above the accumulator width catches the carry-out that
    // signals saturation.
    assign w_sum_zext  = {{(ACC_W+1-SUM_W){1'b0}}, s_sum};
    assign w_acc_sum   = {1'b0, r_acc} + w_sum_zext;
    assign w_count_inc = r_count + c_len_one;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_len_nxt   = r_len;

        case (r_state)
            c_idle: begin
                if (w_beat) begin
                    // First beat cannot overflow since ACC_W >= SUM_W.
                    w_len_nxt   = cfg_len;
                    w_acc_nxt   = w_sum_zext[ACC_W-1:0];
                    w_count_nxt = c_len_one;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = (cfg_len == c_len_one) ? c_hold : c_accum;
                end
            end
            c_accum: begin
                if (w_beat) begin
                    if (w_acc_sum[ACC_W]) begin
                        w_acc_nxt = c_acc_max;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_acc_nxt = w_acc_sum[ACC_W-1:0];
                    end
                    w_count_nxt = w_count_inc;
                    // A latched length of 0 terminates when the count wraps.
                    if (w_count_inc == r_len) begin
                        w_state_nxt = c_hold;
                    end
                end
            end
            c_hold: begin
                if (m_ready) begin
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    assign m_valid = (r_state == c_hold);
    assign m_acc   = r_acc;
    assign m_count = r_count;
    assign m_ovf   = r_ovf;
    assign busy    = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_bk_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bk_sum_accumulator
// Purpose  : Directed self-checking bench for bk_sum_accumulator. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bk_sum_accumulator;

    localparam int SUM_W = 17;
    localparam int ACC_W = 24;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic [LEN_W-1:0] cfg_len;
    logic             s_valid;
    logic             s_ready;
    logic [SUM_W-1:0] s_sum;
    logic             m_valid;
    logic             m_ready;
    logic [ACC_W-1:0] m_acc;
    logic [LEN_W-1:0] m_count;
    logic             m_ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    bk_sum_accumulator #(
        .SUM_W(SUM_W),
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg_len(cfg_len),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_sum  (s_sum),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_acc  (m_acc),
        .m_count(m_count),
        .m_ovf  (m_ovf),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat for exactly one rising edge.
    task automatic send(input logic [SUM_W-1:0] v);
        s_valid = 1'b1;
        s_sum   = v;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Accept a pending result with a one-cycle m_ready pulse.
    task automatic take();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        cfg_len = '0;
        s_valid = 1'b0;
        s_sum   = '0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_acc",     {8'd0, m_acc},    32'd0);
        check("rst_count",   {24'd0, m_count}, 32'd0);
        check("rst_ovf",     {31'd0, m_ovf},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);

        // 1: four beats 1..4 back-to-back with m_ready held high
        cfg_len = 8'd4;
        m_ready = 1'b1;
        send(17'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send(17'd2);
        send(17'd3);
        check("t1_no_valid_early", {31'd0, m_valid}, 32'd0);
        send(17'd4);
        check("t1_m_valid", {31'd0, m_valid}, 32'd1);
        check("t1_acc",     {8'd0, m_acc},    32'd10);
        check("t1_count",   {24'd0, m_count}, 32'd4);
        check("t1_ovf",     {31'd0, m_ovf},   32'd0);
        @(negedge clk);
        m_ready = 1'b0;
        check("t1_taken", {31'd0, m_valid}, 32'd0);
        check("t1_idle",  {31'd0, busy},    32'd0);

        // 2: single-beat frame of the largest adder sum
        cfg_len = 8'd1;
        send(17'h1FFFF);
        check("t2_m_valid", {31'd0, m_valid}, 32'd1);
        check("t2_acc",     {8'd0, m_acc},    32'h0001FFFF);
        check("t2_count",   {24'd0, m_count}, 32'd1);
        check("t2_s_ready", {31'd0, s_ready}, 32'd0);
        take();
        check("t2_taken",   {31'd0, m_valid}, 32'd0);
        check("t2_ready",   {31'd0, s_ready}, 32'd1);

        // 3: 200 beats of 0x1FFFF saturate on beat 129; cfg_len change ignored
        cfg_len = 8'd200;
        send(17'h1FFFF);
        cfg_len = 8'd5;
        for (int i = 1; i < 128; i++) send(17'h1FFFF);
        check("t3_acc_128", {8'd0, m_acc},  32'h00FFFF80);
        check("t3_ovf_128", {31'd0, m_ovf}, 32'd0);
        send(17'h1FFFF);
        check("t3_acc_129", {8'd0, m_acc},  32'h00FFFFFF);
        check("t3_ovf_129", {31'd0, m_ovf}, 32'd1);
        for (int i = 129; i < 199; i++) send(17'h1FFFF);
        check("t3_no_valid_199", {31'd0, m_valid}, 32'd0);
        send(17'h1FFFF);
        check("t3_m_valid", {31'd0, m_valid}, 32'd1);
        check("t3_acc",     {8'd0, m_acc},    32'h00FFFFFF);
        check("t3_count",   {24'd0, m_count}, 32'd200);
        check("t3_ovf",     {31'd0, m_ovf},   32'd1);
        take();

        // 4: result held under back-pressure while s_valid stays high
        cfg_len = 8'd3;
        send(17'd7);
        send(17'd8);
        send(17'd9);
        s_valid = 1'b1;
        s_sum   = 17'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", {31'd0, m_valid}, 32'd1);
            check("t4_hold_acc",   {8'd0, m_acc},    32'd24);
            check("t4_hold_count", {24'd0, m_count}, 32'd3);
        end
        check("t4_hold_ovf",   {31'd0, m_ovf},   32'd0);
        check("t4_hold_ready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        take();
        check("t4_after_busy", {31'd0, busy}, 32'd0);
        cfg_len = 8'd2;
        send(17'd1);
        send(17'd2);
        check("t4_next_acc",   {8'd0, m_acc},    32'd3);
        check("t4_next_count", {24'd0, m_count}, 32'd2);
        check("t4_next_ovf",   {31'd0, m_ovf},   32'd0);
        take();

        // 5: cfg_len=0 means 256 beats; count wraps to 0
        cfg_len = 8'd0;
        for (int i = 0; i < 255; i++) send(17'd1);
        check("t5_no_valid_255", {31'd0, m_valid}, 32'd0);
        check("t5_count_255",    {24'd0, m_count}, 32'd255);
        send(17'd1);
        check("t5_m_valid", {31'd0, m_valid}, 32'd1);
        check("t5_acc",     {8'd0, m_acc},    32'd256);
        check("t5_count",   {24'd0, m_count}, 32'd0);
        take();

        // 6: reset mid-frame discards the partial result
        cfg_len = 8'd4;
        send(17'd3);
        send(17'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_valid", {31'd0, m_valid}, 32'd0);
        check("t6_rst_busy",  {31'd0, busy},    32'd0);
        check("t6_rst_acc",   {8'd0, m_acc},    32'd0);
        check("t6_rst_count", {24'd0, m_count}, 32'd0);
        cfg_len = 8'd2;
        send(17'd5);
        check("t6_no_valid", {31'd0, m_valid}, 32'd0);
        send(17'd5);
        check("t6_m_valid", {31'd0, m_valid}, 32'd1);
        check("t6_acc",     {8'd0, m_acc},    32'd10);
        check("t6_count",   {24'd0, m_count}, 32'd2);
        take();
        check("t6_taken", {31'd0, m_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
